// File: rtl/ramp_phase_gen.sv
// rtl/ramp_phase_gen.sv - phase accumulator driving a 6-bit sawtooth index with valid/ack output and click-free stop
// Optional falling ramp via RAMP_DIR_EN.
module ramp_phase_gen #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [ACC_W-1:0] freq_word,
  input  logic             freq_load,
  input  logic             gate,
`ifdef RAMP_DIR_EN
  input  logic             ramp_dir,
`endif
  output logic [5:0]       ramp,
  output logic             ramp_vld,
  input  logic             ramp_ack,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MID = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [5:0]       IDX_MID = 6'd32;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] freq_q, freq_d;
  logic [5:0]       ramp_q, ramp_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;

  logic [ACC_W-1:0] acc_next;
  logic [5:0]       idx_next;
  logic             crossing;
  logic             emit;
  logic             force_mid;
  logic             dir_w;

`ifdef RAMP_DIR_EN
  assign dir_w = ramp_dir;
`else
  assign dir_w = 1'b0;
`endif

  assign acc_next = acc_q + freq_q;
  assign idx_next = acc_next[ACC_W-1:ACC_W-6];
  // Upward pass through the midpoint: old MSB clear, new MSB set.
  assign crossing = !acc_q[ACC_W-1] && acc_next[ACC_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gate) state_d = RUN;
      end
      RUN: begin
        if (!gate) state_d = DRAIN;
      end
      DRAIN: begin
        if (gate)                   state_d = RUN;
        else if (emit && force_mid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    emit      = sample_en && ((state_q == RUN) || (state_q == DRAIN));
    force_mid = (state_q == DRAIN) && !gate && (crossing || (freq_q == '0));
  end

  always_comb begin
    acc_d  = acc_q;
    ramp_d = ramp_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    freq_d = freq_load ? freq_word : freq_q;
    if (emit) begin
      if (force_mid) begin
        acc_d  = ACC_MID;
        ramp_d = IDX_MID;
      end else begin
        acc_d  = acc_next;
        ramp_d = dir_w ? ~idx_next : idx_next;
      end
      vld_d = 1'b1;
    end else if (ramp_ack) begin
      vld_d = 1'b0;
    end
    // A new overrun beats a simultaneous clear.
    if (emit && vld_q && !ramp_ack) begin
      ovr_d = 1'b1;
    end else if (overrun_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q  <= ACC_MID;
      freq_q <= '0;
      ramp_q <= IDX_MID;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      freq_q <= freq_d;
      ramp_q <= ramp_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign ramp     = ramp_q;
  assign ramp_vld = vld_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_ramp_phase_gen.sv
// tb/tb_ramp_phase_gen.sv - directed vector bench for ramp_phase_gen
module tb_ramp_phase_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en;
  logic [23:0] freq_word;
  logic        freq_load;
  logic        gate;
`ifdef RAMP_DIR_EN
  logic        ramp_dir;
`endif
  logic [5:0]  ramp;
  logic        ramp_vld;
  logic        ramp_ack;
  logic        overrun;
  logic        overrun_clr;
  logic        busy;

  int checks = 0;
  int errors = 0;

  ramp_phase_gen #(.ACC_W(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_en   (sample_en),
    .freq_word   (freq_word),
    .freq_load   (freq_load),
    .gate        (gate),
`ifdef RAMP_DIR_EN
    .ramp_dir    (ramp_dir),
`endif
    .ramp        (ramp),
    .ramp_vld    (ramp_vld),
    .ramp_ack    (ramp_ack),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        se;
    logic        ack;
    logic        ld;
    logic [23:0] fw;
    logic        g;
    logic        clr;
    logic [5:0]  r;
    logic        v;
    logic        ov;
    logic        bz;
  } vec_t;

  vec_t tbl[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [5:0] r, input logic v,
                           input logic ov, input logic bz);
    check({name, ".ramp"}, 32'(ramp), 32'(r));
    check({name, ".vld"}, 32'(ramp_vld), 32'(v));
    check({name, ".overrun"}, 32'(overrun), 32'(ov));
    check({name, ".busy"}, 32'(busy), 32'(bz));
  endtask

  // Inputs change 1 ns after the edge; outputs are sampled there too.
  task automatic cyc(input logic se, input logic ack, input logic ld, input logic [23:0] fw,
                     input logic g, input logic clr);
    sample_en   = se;
    ramp_ack    = ack;
    freq_load   = ld;
    freq_word   = fw;
    gate        = g;
    overrun_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 24'h0, 0, 0);
    cyc(0, 0, 0, 24'h0, 0, 0);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    int idx;
    int nxt;
    int emits;
    bit done;

    reset       = 1'b1;
    sample_en   = 1'b0;
    freq_word   = '0;
    freq_load   = 1'b0;
    gate        = 1'b0;
    ramp_ack    = 1'b0;
    overrun_clr = 1'b0;
`ifdef RAMP_DIR_EN
    ramp_dir    = 1'b0;
`endif

    //            se ack ld fw         g  clr  ramp v  ov bz
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 6'd32, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 6'd32, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 24'h040000, 1'b0, 1'b0, 6'd32, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd32, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd33, 1'b1, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd34, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 6'd34, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd34, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd34, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd35, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd36, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 24'h080000, 1'b1, 1'b0, 6'd37, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd39, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd39, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0, 6'd41, 1'b1, 1'b0, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b1, 6'd43, 1'b1, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b1, 6'd43, 1'b0, 1'b0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 24'h000000, 1'b1, 1'b0, 6'd43, 1'b0, 1'b0, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, 6'd43, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 6'd32, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 24'h000000, 1'b0, 1'b0, 6'd32, 1'b0, 1'b0, 1'b0};

    #1;
    check_out("reset_state", 6'd32, 1'b0, 1'b0, 1'b0);
    do_reset();

    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].se, tbl[i].ack, tbl[i].ld, tbl[i].fw, tbl[i].g, tbl[i].clr);
      check_out($sformatf("vec%0d", i), tbl[i].r, tbl[i].v, tbl[i].ov, tbl[i].bz);
    end

    // Full cycle of step 1 with an ack cycle between samples.
    do_reset();
    cyc(0, 0, 1, 24'h040000, 1, 0);
    cyc(0, 0, 0, 24'h0, 1, 0);
    for (int i = 0; i < 64; i++) begin
      cyc(1, 0, 0, 24'h0, 1, 0);
      check($sformatf("sweep%0d.ramp", i), 32'(ramp), 32'((33 + i) % 64));
      check($sformatf("sweep%0d.vld", i), 32'(ramp_vld), 32'd1);
      cyc(0, 1, 0, 24'h0, 1, 0);
      check($sformatf("sweep%0d.vld_clr", i), 32'(ramp_vld), 32'd0);
    end
    check("sweep.overrun", 32'(overrun), 32'd0);

    // Reset in the middle of RUN with a pending sample and overrun set.
    cyc(1, 0, 0, 24'h0, 1, 0);
    cyc(1, 0, 0, 24'h0, 1, 0);
    check("pre_reset.overrun", 32'(overrun), 32'd1);
    reset = 1'b1;
    #1;
    check_out("async_reset", 6'd32, 1'b0, 1'b0, 1'b0);
    cyc(0, 0, 0, 24'h0, 0, 0);
    reset = 1'b0;
    #1;

    // Step 3: run to 41, release the gate, drain until the upward midpoint crossing.
    cyc(0, 0, 1, 24'h0C0000, 1, 0);
    cyc(0, 0, 0, 24'h0, 1, 0);
    idx = 32;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 24'h0, 1, 0);
      idx = (idx + 3) % 64;
      check($sformatf("run3_%0d", i), 32'(ramp), 32'(idx));
    end
    check("run3.last", 32'(ramp), 32'd41);
    cyc(0, 1, 0, 24'h0, 0, 0);
    check("drain.busy", 32'(busy), 32'd1);
    emits = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      cyc(1, 1, 0, 24'h0, 0, 0);
      emits++;
      nxt = (idx + 3) % 64;
      if (idx < 32 && nxt >= 32) begin
        check("drain.forced", 32'(ramp), 32'd32);
        check("drain.idle", 32'(busy), 32'd0);
        done = 1'b1;
      end else begin
        check($sformatf("drain%0d", i), 32'(ramp), 32'(nxt));
        check($sformatf("drain%0d.busy", i), 32'(busy), 32'd1);
        idx = nxt;
      end
    end
    check("drain.completed", 32'(done), 32'd1);
    check("drain.emits", 32'(emits), 32'd19);
    cyc(0, 1, 0, 24'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 24'h0, 0, 0);
      check($sformatf("idle_ignore%0d.vld", i), 32'(ramp_vld), 32'd0);
      check($sformatf("idle_ignore%0d.ramp", i), 32'(ramp), 32'd32);
    end

`ifdef RAMP_DIR_EN
    // Falling ramp, then drain back to the midpoint.
    do_reset();
    ramp_dir = 1'b1;
    cyc(0, 0, 1, 24'h040000, 1, 0);
    cyc(0, 0, 0, 24'h0, 1, 0);
    cyc(1, 1, 0, 24'h0, 1, 0);
    check("dir.first", 32'(ramp), 32'd30);
    cyc(1, 1, 0, 24'h0, 1, 0);
    check("dir.second", 32'(ramp), 32'd29);
    cyc(0, 1, 0, 24'h0, 0, 0);
    done = 1'b0;
    for (int i = 0; i < 80 && !done; i++) begin
      cyc(1, 1, 0, 24'h0, 0, 0);
      if (busy == 1'b0) done = 1'b1;
    end
    check("dir.drained", 32'(done), 32'd1);
    check("dir.forced", 32'(ramp), 32'd32);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
